// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared FSM encoding and gate-window helpers for freq_meter.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam int GATE_BITS_DEF = 8;
    localparam int GATE_LAST     = (1 << GATE_BITS_DEF) - 1;
    localparam int SYNC_MIN      = 2;

    // Terminal gate count for an arbitrary window width.
    function automatic int gate_last(input int gate_bits);
        return (1 << gate_bits) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Multi-stage synchroniser followed by a rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic rise
);

    // Chains shorter than two flops are not metastability-safe.
    localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_chain;
    logic              sync_dly;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_chain <= '0;
            sync_dly   <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[STAGES-2:0], sig_in};
            sync_dly   <= sync_chain[STAGES-1];
        end
    end

    assign rise = sync_chain[STAGES-1] & ~sync_dly;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Counts rising edges of sig_in over a 2^GATE_BITS cycle window.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_BITS   = 8,
    parameter int CNT_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                sig_in,
    input  logic                start_in,
    input  logic                cont_in,
    output logic [CNT_BITS-1:0] count_out,
    output logic                valid_out,
    output logic                ovf_out,
    output logic                busy_out
);

    localparam logic [GATE_BITS-1:0] LAST = GATE_BITS'(gate_last(GATE_BITS));

    logic                 rise;
    logic [0:0]           state;
    logic [GATE_BITS-1:0] gate_cnt;
    logic [CNT_BITS-1:0]  edge_cnt;
    logic [CNT_BITS-1:0]  edge_next;
    logic                 ovf_flag;
    logic                 ovf_next;
    logic                 terminal;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // Saturating edge count; a blocked increment marks the window as overflowed.
    always_comb begin
        edge_next = edge_cnt;
        ovf_next  = ovf_flag;
        if (rise) begin
            if (&edge_cnt) begin
                ovf_next = 1'b1;
            end else begin
                edge_next = edge_cnt + 1'b1;
            end
        end
    end

    assign terminal = (gate_cnt == LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            ovf_flag  <= 1'b0;
            count_out <= '0;
            valid_out <= 1'b0;
            ovf_out   <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in || cont_in) begin
                        state    <= ST_MEASURE;
                        busy_out <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (terminal) begin
                        count_out <= edge_next;
                        ovf_out   <= ovf_next;
                        valid_out <= 1'b1;
                        gate_cnt  <= '0;
                        edge_cnt  <= '0;
                        ovf_flag  <= 1'b0;
                        // Continuous mode re-arms with no dead cycle.
                        if (!cont_in) begin
                            state    <= ST_IDLE;
                            busy_out <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= edge_next;
                        ovf_flag <= ovf_next;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a 1-bit input by counting its rising edges over a fixed gate window of 2^GATE_BITS clk_in cycles.
- Companion to the phase-accumulator NCO: it sits on the observing side of an NCO output, typically the accumulator MSB, and recovers a count proportional to the frequency control word: count ≈ fcw·2^GATE_BITS / 2^NCO_BITS.
- Used for self-check and loopback of NCO-based generators, and for measuring external square waves after synchronisation.

Parameters:
- GATE_BITS, 8, log2 of gate window length in clk_in cycles.
- CNT_BITS, 8, width of the edge count result. The counter saturates at 2^CNT_BITS-1.
- SYNC_STAGES, 2, number of flip-flops in the sig_in synchroniser (minimum 2).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- sig_in  input  1  signal under measurement; may be asynchronous to clk_in.
- start_in  input  1  single-shot request, sampled in IDLE.
- cont_in  input  1  continuous mode: re-arm automatically after each window.
- count_out  output  CNT_BITS  last completed edge count (held until the next result).
- valid_out  output  1  one-cycle pulse when count_out updates.
- ovf_out  output  1  the edge counter saturated during the window that produced count_out.
- busy_out  output  1  high while in MEASURE.

Behaviour:
- Reset:
  - The async reset clears the synchroniser chain, the edge-detect register, the gate counter, the edge counter, count_out, valid_out, ovf_out and busy_out to 0.
  - The FSM goes to IDLE.
- Synchroniser and edge detect:
  - sig_in passes through SYNC_STAGES flip-flops, followed by one delay register.
  - A rising edge is sync=1 while the delayed copy=0.
  - Latency from a sig_in rise to edge detection is SYNC_STAGES+1 cycles.
  - Edges are tracked in every state, so the first cycle of a window cannot see a false edge.
- FSM states: IDLE, MEASURE.
  - IDLE → MEASURE when start_in=1 or cont_in=1. Entering MEASURE clears the gate counter and edge counter.
  - MEASURE:
    - The gate counter increments every cycle.
    - The edge counter increments on each detected edge, saturating at all-ones, and sets an internal ovf flag when an increment is blocked.
    - The terminal cycle is gate counter = 2^GATE_BITS-1. An edge detected in the terminal cycle is included in the result.
    - The window is exactly 2^GATE_BITS cycles.
  - On the terminal cycle:
    - count_out is loaded with the final count and ovf_out with the final ovf flag.
    - valid_out is registered high for the following cycle only.
    - Then, if cont_in=1: stay in MEASURE with counters cleared. There is no dead cycle, so windows are back-to-back and a valid_out pulse occurs every 2^GATE_BITS cycles. Otherwise go to IDLE.
- busy_out = (state==MEASURE), registered with the state.
- start_in while busy is ignored. start_in is a level sampled only in IDLE; if it is held high, windows repeat with one IDLE cycle between them.
- Dropping cont_in mid-window completes the current window, then returns to IDLE.
- Maximum synchronised edge rate is 1 edge per 2 cycles, so the un-saturated maximum is 2^(GATE_BITS-1). Default CNT_BITS=8 therefore never saturates.
- Asserting rst_in mid-window aborts the window: no valid_out, and count_out returns to 0.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE, ST_MEASURE) and the localparam GATE_LAST = 2^GATE_BITS-1.
- One natural sub-module: sync_edge_det (parameter SYNC_STAGES; input sig_in; output rise pulse). The NCO-facing receivers will reuse it.

Test Plan:
- sig_in=0 constant, one start_in pulse → after 256 cycles count_out=0, valid_out high for exactly 1 cycle, ovf_out=0, busy_out then 0.
- sig_in toggling every cycle (period 2), single shot, GATE_BITS=8 → count_out=128, ovf_out=0.
- sig_in period 4 (2 high/2 low), cont_in=1 for 3 windows → three valid_out pulses spaced exactly 256 cycles apart, each count_out=64; dropping cont_in mid-third window gives a fourth result of 64 at that window's end, then IDLE.
- sig_in driven by the accumulator MSB of the 4-bit NCO with fcw=1 (period 16) → count_out ∈ {15,16} for each window; with fcw=4 (period 4) → count_out ∈ {63,64}.
- Override CNT_BITS=4, sig_in period 2 → count_out=15, ovf_out=1; next window with sig_in=0 → count_out=0, ovf_out=0.
- rst_in asserted at gate cycle 100 of a window → all outputs 0 immediately, no valid_out; new start_in after release yields a correct full-window count.
